sdr_send_sched: RTL and testbench
=================================

SDR_SEND_SCHED -- requirements
Module: sdr_send_sched

Interface
REQ-001 Parameter NR, default 8, number of DDC streams (1..16).
REQ-002 Parameter STUCK_LIMIT, default 250000000, watchdog timeout in tx_clock cycles.
REQ-003 tx_clock  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous and active-low.
REQ-005 run  in  1  streaming enabled by host.
REQ-006 resp_req  in  1  discovery/erase/send-more response pending (level).
REQ-007 cc_ready  in  1  C&C status packet pending (level).
REQ-008 mic_ready  in  1  mic FIFO holds one packet (level).
REQ-009 wb_ready  in  1  wideband first packet of a frame pending (level).
REQ-010 wb_more  in  1  wideband continuation packets pending (level).
REQ-011 ddc_ready  in  NR  per-DDC FIFO holds one packet (level, bit i = DDC i).
REQ-012 tx_done  in  1  one-cycle pulse from packet sender: granted packet fully sent.
REQ-013 grant_valid  out  1  a grant is held.
REQ-014 grant_class  out  3  0 none, 1 RESP, 2 CC, 3 MIC, 4 WB, 5 DDC.
REQ-015 grant_port  out  4  DDC index when grant_class=5, else 0.
REQ-016 phy_ready  out  1  high when no DDC grant held and ddc_ready==0.
REQ-017 abort  out  1  one-cycle pulse on watchdog abort.

Function
REQ-018 States SHALL be IDLE, GRANT, GAP; encoding free.
REQ-019 IDLE: if any eligible request, register grant, grant_valid=1, go GRANT the next cycle; else stay.
REQ-020 Eligibility: resp_req always; all other classes only when run=1.
REQ-021 Fixed priority: RESP > CC > MIC > WB(wb_ready) > DDC > WB(wb_more).
REQ-022 wb_more continuation SHALL be granted only when ddc_ready==0 (class 4).
REQ-023 DDC selection: round-robin starting at rr_ptr, first set bit in circular order rr_ptr..NR-1,0..rr_ptr-1.
REQ-024 On a DDC grant to port p, rr_ptr SHALL become p+1, wrapping NR-1 -> 0.
REQ-025 GRANT: hold grant_class/grant_port/grant_valid stable until tx_done sampled high; request changes ignored.
REQ-026 On tx_done in GRANT: grant_valid=0, class=0, port=0 next cycle; go GAP.
REQ-027 GAP lasts exactly one cycle, then IDLE; earliest next grant is 2 cycles after tx_done.
REQ-028 tx_done outside GRANT SHALL be ignored.
REQ-029 run falling in GRANT SHALL NOT by itself release the grant (watchdog only).
REQ-030 When run=0 in IDLE, rr_ptr SHALL reset to 0.
REQ-031 Grant registers update only on state transitions; outputs are registered, no combinational path input->output except phy_ready.

Reset
REQ-032 rst_n low SHALL asynchronously force state IDLE, rr_ptr 0, grant_valid 0, grant_class 0, grant_port 0, abort 0, watchdog counter 0.
REQ-033 Reset mid-grant SHALL drop the grant immediately, with no tx_done required.
REQ-034 phy_ready during reset SHALL equal (ddc_ready==0).

Configuration
REQ-035 Macro SEND_SCHED_WATCHDOG_EN selects the watchdog.
REQ-036 Defined: in GRANT with run=0, counter increments per cycle; at STUCK_LIMIT, pulse abort one cycle, clear grant, go IDLE, counter 0; counter clears whenever run=1 or not in GRANT.
REQ-037 Not defined: no counter logic, abort tied 0, GRANT exits only on tx_done.

Verification
REQ-038 run=1, cc_ready=1, mic_ready=1, ddc_ready=8'h01 -> grants in order CC(2), MIC(3), DDC port 0, each after its tx_done.
REQ-039 NR=8, ddc_ready=8'hFF held, 8 tx_done pulses -> grant_port sequence 0,1,...,7, then 0.
REQ-040 rr_ptr=3, ddc_ready=8'h05 -> grant_port 0, then rr_ptr=1; next grant port 2.
REQ-041 run=0, resp_req=1, cc_ready=1 -> only RESP(1) granted; tx_done -> grant_valid=0 one cycle later, GAP one cycle, no further grant.
REQ-042 wb_more=1, ddc_ready=8'h02 -> DDC port 1 granted first; after its tx_done and ddc_ready=0, WB(4) granted.
REQ-043 Watchdog build, STUCK_LIMIT=16: DDC grant, run dropped -> abort pulse 16 cycles later, grant_valid=0, state IDLE; non-watchdog build -> grant held indefinitely.

Source files
------------

// File: rtl/sdr_send_sched_if.sv
// sdr_send_sched_if: request/grant bundle between the packet sources, the
// packet sender and the send scheduler.
//   master : host/sender side (drives requests and tx_done)
//   slave  : scheduler side (drives the grant, phy_ready and abort)
interface sdr_send_sched_if #(
  parameter int NR = 8
);
  logic          run;
  logic          resp_req;
  logic          cc_ready;
  logic          mic_ready;
  logic          wb_ready;
  logic          wb_more;
  logic [NR-1:0] ddc_ready;
  logic          tx_done;
  logic          grant_valid;
  logic [2:0]    grant_class;
  logic [3:0]    grant_port;
  logic          phy_ready;
  logic          abort;

  modport master (
    output run, resp_req, cc_ready, mic_ready, wb_ready, wb_more,
    output ddc_ready, tx_done,
    input  grant_valid, grant_class, grant_port, phy_ready, abort
  );

  modport slave (
    input  run, resp_req, cc_ready, mic_ready, wb_ready, wb_more,
    input  ddc_ready, tx_done,
    output grant_valid, grant_class, grant_port, phy_ready, abort
  );
endinterface

// File: rtl/sdr_send_sched.sv
// sdr_send_sched: grants the single packet sender to one source at a time.
// Fixed priority RESP > CC > MIC > WB(first) > DDC > WB(continuation), with
// round-robin among the DDC streams. A grant is held until tx_done, followed
// by a one-cycle gap before the next arbitration.
// Optional build macro SEND_SCHED_WATCHDOG_EN adds a watchdog that aborts a
// grant left hanging for STUCK_LIMIT cycles after run drops; without it the
// abort output stays low and a grant is released only by tx_done.
module sdr_send_sched #(
  parameter int NR          = 8,
  parameter int STUCK_LIMIT = 250000000
) (
  input  logic              tx_clock,
  input  logic              rst_n,
  sdr_send_sched_if.slave   bus
);

  localparam logic [2:0] CLS_NONE = 3'd0;
  localparam logic [2:0] CLS_RESP = 3'd1;
  localparam logic [2:0] CLS_CC   = 3'd2;
  localparam logic [2:0] CLS_MIC  = 3'd3;
  localparam logic [2:0] CLS_WB   = 3'd4;
  localparam logic [2:0] CLS_DDC  = 3'd5;

  // Index width used to address one DDC request bit.
  localparam int IW = (NR > 1) ? $clog2(NR) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t        state_r;
  logic [3:0]    rr_ptr_r;
  logic          grant_valid_r;
  logic [2:0]    grant_class_r;
  logic [3:0]    grant_port_r;
  logic          abort_r;

  logic [NR-1:0] ddc_s;
  logic          ddc_any_s;
  logic [4:0]    ddc_pick_s;
  logic [3:0]    rr_next_s;
  logic          req_any_s;
  logic [2:0]    nxt_class_s;
  logic [3:0]    nxt_port_s;
  logic          wd_fire_s;

  // Round-robin pick: first set bit walking ptr..NR-1, 0..ptr-1.
  // Returns {found, port}.
  function automatic logic [4:0] rr_pick(input logic [NR-1:0] req,
                                         input logic [3:0]    ptr);
    logic          found;
    logic [3:0]    port;
    int            idx;
    logic [IW-1:0] idx_w;
    found = 1'b0;
    port  = 4'd0;
    for (int i = 0; i < NR; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NR) begin
        idx = idx - NR;
      end
      idx_w = IW'(idx);
      if (!found && req[idx_w]) begin
        found = 1'b1;
        port  = 4'(idx);
      end
    end
    return {found, port};
  endfunction

  assign ddc_s      = bus.ddc_ready;
  assign ddc_any_s  = (ddc_s != {NR{1'b0}});
  assign ddc_pick_s = rr_pick(ddc_s, rr_ptr_r);

  // Pointer after a grant to the picked port, wrapping the last stream to 0.
  always_comb begin
    rr_next_s = 4'd0;
    if (ddc_pick_s[3:0] == 4'(NR - 1)) begin
      rr_next_s = 4'd0;
    end else begin
      rr_next_s = ddc_pick_s[3:0] + 4'd1;
    end
  end

  // Fixed-priority selection of the next grant; only RESP ignores run.
  always_comb begin
    req_any_s   = 1'b0;
    nxt_class_s = CLS_NONE;
    nxt_port_s  = 4'd0;
    if (bus.resp_req) begin
      req_any_s   = 1'b1;
      nxt_class_s = CLS_RESP;
    end else if (bus.run && bus.cc_ready) begin
      req_any_s   = 1'b1;
      nxt_class_s = CLS_CC;
    end else if (bus.run && bus.mic_ready) begin
      req_any_s   = 1'b1;
      nxt_class_s = CLS_MIC;
    end else if (bus.run && bus.wb_ready) begin
      req_any_s   = 1'b1;
      nxt_class_s = CLS_WB;
    end else if (bus.run && ddc_pick_s[4]) begin
      req_any_s   = 1'b1;
      nxt_class_s = CLS_DDC;
      nxt_port_s  = ddc_pick_s[3:0];
    end else if (bus.run && bus.wb_more && !ddc_any_s) begin
      req_any_s   = 1'b1;
      nxt_class_s = CLS_WB;
    end else begin
      req_any_s   = 1'b0;
      nxt_class_s = CLS_NONE;
      nxt_port_s  = 4'd0;
    end
  end

`ifdef SEND_SCHED_WATCHDOG_EN
  localparam int CW = $clog2(STUCK_LIMIT + 1);

  logic [CW-1:0] wd_cnt_r;

  // Fires on the STUCK_LIMIT-th consecutive cycle of a grant held with run low.
  assign wd_fire_s = (state_r == S_GRANT) && !bus.run &&
                     (wd_cnt_r == CW'(STUCK_LIMIT - 1));

  // Watchdog counter: counts grant cycles with run low, cleared otherwise.
  always_ff @(posedge tx_clock or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt_r <= {CW{1'b0}};
    end else if ((state_r != S_GRANT) || bus.run || wd_fire_s) begin
      wd_cnt_r <= {CW{1'b0}};
    end else begin
      wd_cnt_r <= wd_cnt_r + {{(CW-1){1'b0}}, 1'b1};
    end
  end
`else
  assign wd_fire_s = 1'b0;
`endif

  // Scheduler FSM with registered grant outputs and abort pulse.
  always_ff @(posedge tx_clock or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= S_IDLE;
      rr_ptr_r      <= 4'd0;
      grant_valid_r <= 1'b0;
      grant_class_r <= CLS_NONE;
      grant_port_r  <= 4'd0;
      abort_r       <= 1'b0;
    end else begin
      abort_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (!bus.run) begin
            rr_ptr_r <= 4'd0;
          end
          if (req_any_s) begin
            state_r       <= S_GRANT;
            grant_valid_r <= 1'b1;
            grant_class_r <= nxt_class_s;
            grant_port_r  <= nxt_port_s;
            if (nxt_class_s == CLS_DDC) begin
              rr_ptr_r <= rr_next_s;
            end
          end
        end
        S_GRANT: begin
          if (bus.tx_done) begin
            state_r       <= S_GAP;
            grant_valid_r <= 1'b0;
            grant_class_r <= CLS_NONE;
            grant_port_r  <= 4'd0;
          end else if (wd_fire_s) begin
            state_r       <= S_IDLE;
            grant_valid_r <= 1'b0;
            grant_class_r <= CLS_NONE;
            grant_port_r  <= 4'd0;
            abort_r       <= 1'b1;
          end
        end
        S_GAP: begin
          state_r <= S_IDLE;
        end
        default: begin
          state_r       <= S_IDLE;
          grant_valid_r <= 1'b0;
          grant_class_r <= CLS_NONE;
          grant_port_r  <= 4'd0;
        end
      endcase
    end
  end

  assign bus.grant_valid = grant_valid_r;
  assign bus.grant_class = grant_class_r;
  assign bus.grant_port  = grant_port_r;
  assign bus.abort       = abort_r;
  // The PHY may be reclaimed only when no DDC stream holds or wants the sender.
  assign bus.phy_ready   = !(grant_valid_r && (grant_class_r == CLS_DDC)) &&
                           !ddc_any_s;

endmodule

// File: tb/tb_sdr_send_sched.sv
// tb_sdr_send_sched: scoreboard bench for sdr_send_sched (NR=8, STUCK_LIMIT=16).
// Expected grants are queued as requests are raised and popped when the
// scheduler presents a grant.
module tb_sdr_send_sched;

  localparam int NR       = 8;
  localparam int LIMIT    = 16;
  localparam int WAIT_MAX = 50;

  logic tx_clock;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  logic [6:0] exp_q[$];

  sdr_send_sched_if #(.NR(NR)) bus ();

  sdr_send_sched #(.NR(NR), .STUCK_LIMIT(LIMIT)) dut (
    .tx_clock (tx_clock),
    .rst_n    (rst_n),
    .bus      (bus)
  );

  initial begin
    tx_clock = 1'b0;
    forever #5 tx_clock = ~tx_clock;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Wait for the next grant, compare it with the scoreboard head and latency.
  task automatic serve(input string tag, input int exp_cyc);
    int         cyc;
    logic [6:0] e;
    cyc = 0;
    do begin
      @(negedge tx_clock);
      cyc++;
    end while (!bus.grant_valid && cyc < WAIT_MAX);
    chk({tag, "_seen"}, bus.grant_valid, 1'b1);
    chk({tag, "_qhas"}, (exp_q.size() > 0), 1'b1);
    if (bus.grant_valid && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, "_grant"}, {bus.grant_class, bus.grant_port}, e);
    end
    if (exp_cyc > 0) chk({tag, "_lat"}, cyc, exp_cyc);
  endtask

  // Pulse tx_done, check release next cycle and the one-cycle gap after it.
  task automatic send_done(input string tag);
    bus.tx_done = 1'b1;
    @(negedge tx_clock);
    bus.tx_done = 1'b0;
    chk({tag, "_rel"}, {bus.grant_valid, bus.grant_class, bus.grant_port}, 8'h00);
    @(negedge tx_clock);
    chk({tag, "_gap"}, bus.grant_valid, 1'b0);
  endtask

  initial begin
    #2ms;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    n_checks = 0;
    n_fail   = 0;
    rst_n         = 1'b0;
    bus.run       = 1'b0;
    bus.resp_req  = 1'b0;
    bus.cc_ready  = 1'b0;
    bus.mic_ready = 1'b0;
    bus.wb_ready  = 1'b0;
    bus.wb_more   = 1'b0;
    bus.ddc_ready = 8'h00;
    bus.tx_done   = 1'b0;

    // Reset state and phy_ready during reset.
    repeat (3) @(negedge tx_clock);
    chk("rst_valid", bus.grant_valid, 1'b0);
    chk("rst_class_port", {bus.grant_class, bus.grant_port}, 7'h00);
    chk("rst_abort", bus.abort, 1'b0);
    chk("rst_phy_idle", bus.phy_ready, 1'b1);
    bus.ddc_ready = 8'h10;
    #1;
    chk("rst_phy_busy", bus.phy_ready, 1'b0);
    bus.ddc_ready = 8'h00;
    @(negedge tx_clock);
    rst_n = 1'b1;
    @(negedge tx_clock);

    // Full priority ladder with every source requesting.
    bus.run = 1'b1; bus.resp_req = 1'b1; bus.cc_ready = 1'b1; bus.mic_ready = 1'b1;
    bus.wb_ready = 1'b1; bus.wb_more = 1'b1; bus.ddc_ready = 8'h01;
    exp_q.push_back({3'd1, 4'd0}); exp_q.push_back({3'd2, 4'd0});
    exp_q.push_back({3'd3, 4'd0}); exp_q.push_back({3'd4, 4'd0});
    exp_q.push_back({3'd5, 4'd0}); exp_q.push_back({3'd4, 4'd0});
    serve("pri_resp", 1);
    bus.resp_req = 1'b0;
    chk("phy_ddc_pending", bus.phy_ready, 1'b0);
    repeat (3) begin
      @(negedge tx_clock);
      chk("hold_resp", {bus.grant_valid, bus.grant_class}, 4'h9);
    end
    send_done("pri_resp");
    serve("pri_cc", 1);   bus.cc_ready = 1'b0;  send_done("pri_cc");
    serve("pri_mic", 1);  bus.mic_ready = 1'b0; send_done("pri_mic");
    serve("pri_wbf", 1);  bus.wb_ready = 1'b0;  send_done("pri_wbf");
    serve("pri_ddc", 1);  bus.ddc_ready = 8'h00;
    #1;
    chk("phy_ddc_held", bus.phy_ready, 1'b0);
    send_done("pri_ddc");
    chk("phy_free", bus.phy_ready, 1'b1);
    serve("pri_wbm", 1);  bus.wb_more = 1'b0;   send_done("pri_wbm");

    // CC, MIC, then DDC port 0.
    bus.cc_ready = 1'b1; bus.mic_ready = 1'b1; bus.ddc_ready = 8'h01;
    exp_q.push_back({3'd2, 4'd0}); exp_q.push_back({3'd3, 4'd0});
    exp_q.push_back({3'd5, 4'd0});
    serve("seq_cc", 1);  bus.cc_ready = 1'b0;   send_done("seq_cc");
    serve("seq_mic", 1); bus.mic_ready = 1'b0;  send_done("seq_mic");
    serve("seq_ddc", 1); bus.ddc_ready = 8'h00; send_done("seq_ddc");

    // run low: only RESP is eligible; rr_ptr returns to 0 while idle.
    bus.run = 1'b0; bus.resp_req = 1'b1; bus.cc_ready = 1'b1;
    exp_q.push_back({3'd1, 4'd0});
    serve("norun_resp", 1);
    bus.resp_req = 1'b0;
    send_done("norun_resp");
    repeat (6) begin
      @(negedge tx_clock);
      chk("norun_nogrant", bus.grant_valid, 1'b0);
    end
    bus.cc_ready = 1'b0;

    // Round-robin sweep over all eight streams.
    bus.run = 1'b1; bus.ddc_ready = 8'hFF;
    for (int i = 0; i < 9; i++) exp_q.push_back({3'd5, 4'(i % NR)});
    for (int i = 0; i < 9; i++) begin
      serve("rr_sweep", 1);
      if (i == 8) bus.ddc_ready = 8'h00;
      send_done("rr_sweep");
    end

    // rr_ptr=3 with requests on 0 and 2: port 0, then port 2.
    bus.run = 1'b0;
    repeat (2) @(negedge tx_clock);
    bus.run = 1'b1; bus.ddc_ready = 8'h04;
    exp_q.push_back({3'd5, 4'd2}); exp_q.push_back({3'd5, 4'd0});
    exp_q.push_back({3'd5, 4'd2});
    serve("rr3_setup", 1); bus.ddc_ready = 8'h05; send_done("rr3_setup");
    serve("rr3_wrap", 1);  send_done("rr3_wrap");
    serve("rr3_next", 1);  bus.ddc_ready = 8'h00; send_done("rr3_next");

    // WB continuation waits behind DDC.
    bus.wb_more = 1'b1; bus.ddc_ready = 8'h02;
    exp_q.push_back({3'd5, 4'd1});
    serve("wbm_ddc", 1); bus.ddc_ready = 8'h00; send_done("wbm_ddc");
    exp_q.push_back({3'd4, 4'd0});
    serve("wbm_wb", 1);  bus.wb_more = 1'b0;    send_done("wbm_wb");

    // tx_done while idle must not disturb the next grant.
    bus.tx_done = 1'b1;
    @(negedge tx_clock);
    bus.tx_done = 1'b0;
    chk("idle_txdone", bus.grant_valid, 1'b0);

    // run dropping during a DDC grant.
    bus.ddc_ready = 8'h01;
    exp_q.push_back({3'd5, 4'd0});
    serve("stuck_grant", 1);
    bus.run = 1'b0; bus.ddc_ready = 8'h00;
`ifdef SEND_SCHED_WATCHDOG_EN
    cnt = 0;
    do begin
      @(negedge tx_clock);
      cnt++;
    end while (!bus.abort && cnt < 40);
    chk("wd_abort_seen", bus.abort, 1'b1);
    chk("wd_latency", cnt, LIMIT);
    chk("wd_released", bus.grant_valid, 1'b0);
    bus.run = 1'b1; bus.ddc_ready = 8'h01;
    @(negedge tx_clock);
    chk("wd_abort_pulse", bus.abort, 1'b0);
    exp_q.push_back({3'd5, 4'd0});
    chk("wd_regrant_valid", bus.grant_valid, 1'b1);
    chk("wd_regrant", {bus.grant_class, bus.grant_port}, exp_q.pop_front());
    bus.ddc_ready = 8'h00;
    send_done("wd_regrant");
`else
    cnt = 0;
    repeat (40) begin
      @(negedge tx_clock);
      if (bus.abort !== 1'b0 || bus.grant_valid !== 1'b1) cnt++;
    end
    chk("nowd_bad_cycles", cnt, 0);
    chk("nowd_held", {bus.grant_valid, bus.grant_class, bus.grant_port}, 8'hD0);
    send_done("nowd_release");
    bus.run = 1'b1;
`endif

    // Asynchronous reset in the middle of a grant.
    bus.ddc_ready = 8'h01;
    exp_q.push_back({3'd5, 4'd0});
    serve("rst_mid", 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_drop", {bus.grant_valid, bus.grant_class, bus.grant_port}, 8'h00);
    chk("rst_mid_phy_busy", bus.phy_ready, 1'b0);
    bus.ddc_ready = 8'h00;
    #1;
    chk("rst_mid_phy_free", bus.phy_ready, 1'b1);
    @(negedge tx_clock);
    rst_n = 1'b1;
    @(negedge tx_clock);
    chk("end_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
